// File: rtl/gpu_pkg.sv
// Shared types and defaults for the GPU thread dispatch path.
package gpu_pkg;

  localparam int NUM_THREADS_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT     = 64;
  localparam int RESULT_W            = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_LOAD = 3'b110,
    OP_NOP  = 3'b111
  } instr_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dispatch_state_e;

endpackage

// File: rtl/thread_dispatcher_if.sv
// Request, lane broadcast and response signals of the thread dispatcher.
// The dispatcher uses the slave view; the host and lanes use the master view.
interface thread_dispatcher_if
  import gpu_pkg::*;
#(
  parameter int NUM_THREADS = NUM_THREADS_DEFAULT
) ();

  logic                            req_valid;
  logic                            req_ready;
  logic [2:0]                      req_type;
  logic [4:0]                      req_regnum_1;
  logic [4:0]                      req_regnum_2;
  logic [4:0]                      req_dest_reg;
  logic [5:0]                      req_shammt;
  logic [NUM_THREADS-1:0]          req_mask;

  logic [2:0]                      fu_type_instruction;
  logic [4:0]                      fu_regnum_1;
  logic [4:0]                      fu_regnum_2;
  logic [4:0]                      fu_dest_reg;
  logic [5:0]                      fu_shammt;
  logic [NUM_THREADS-1:0]          fu_is_active;
  logic [NUM_THREADS-1:0]          fu_thread_complete;
  logic [NUM_THREADS*RESULT_W-1:0] fu_final_result;

  logic                            res_valid;
  logic                            res_ready;
  logic [NUM_THREADS*RESULT_W-1:0] res_data;
  logic [NUM_THREADS-1:0]          res_mask;
  logic                            res_timeout;
  logic                            busy;

  modport slave (
    input  req_valid, req_type, req_regnum_1, req_regnum_2, req_dest_reg,
           req_shammt, req_mask, fu_thread_complete, fu_final_result, res_ready,
    output req_ready, fu_type_instruction, fu_regnum_1, fu_regnum_2,
           fu_dest_reg, fu_shammt, fu_is_active, res_valid, res_data,
           res_mask, res_timeout, busy
  );

  modport master (
    output req_valid, req_type, req_regnum_1, req_regnum_2, req_dest_reg,
           req_shammt, req_mask, fu_thread_complete, fu_final_result, res_ready,
    input  req_ready, fu_type_instruction, fu_regnum_1, fu_regnum_2,
           fu_dest_reg, fu_shammt, fu_is_active, res_valid, res_data,
           res_mask, res_timeout, busy
  );

endinterface

// File: rtl/thread_done_tracker.sv
// Sticky per-lane completion mask plus a result register per lane that
// captures the lane's value on the first cycle its completion is seen.
module thread_done_tracker
  import gpu_pkg::*;
#(
  parameter int NUM_THREADS = NUM_THREADS_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_clear,
  input  logic                            i_enable,
  input  logic [NUM_THREADS-1:0]          i_mask,
  input  logic [NUM_THREADS-1:0]          i_complete,
  input  logic [NUM_THREADS*RESULT_W-1:0] i_result,
  output logic [NUM_THREADS-1:0]          o_done_mask,
  output logic [NUM_THREADS-1:0]          o_done_next,
  output logic [NUM_THREADS*RESULT_W-1:0] o_results
);

  logic [NUM_THREADS-1:0]          r_done;
  logic [NUM_THREADS*RESULT_W-1:0] r_results;
  logic [NUM_THREADS-1:0]          w_new;

  // Only lanes in the mask that have not completed before may capture.
  assign w_new       = i_complete & i_mask & ~r_done;
  assign o_done_next = r_done | (i_complete & i_mask);
  assign o_done_mask = r_done;
  assign o_results   = r_results;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done    <= '0;
      r_results <= '0;
    end else if (i_clear) begin
      r_done    <= '0;
      r_results <= '0;
    end else if (i_enable) begin
      r_done <= o_done_next;
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (w_new[i]) begin
          r_results[i*RESULT_W +: RESULT_W] <= i_result[i*RESULT_W +: RESULT_W];
        end
      end
    end
  end

endmodule

// File: rtl/thread_dispatcher.sv
// Thread dispatcher: issues one instruction to all active func_unit lanes and
// returns their results once every lane completes or the wait times out.
module thread_dispatcher
  import gpu_pkg::*;
#(
  parameter int NUM_THREADS = NUM_THREADS_DEFAULT,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  thread_dispatcher_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  dispatch_state_e r_state;
  dispatch_state_e w_next_state;

  logic [NUM_THREADS-1:0]          r_mask;
  logic [2:0]                      r_fu_type;
  logic [4:0]                      r_fu_reg1;
  logic [4:0]                      r_fu_reg2;
  logic [4:0]                      r_fu_dest;
  logic [5:0]                      r_fu_shammt;
  logic [NUM_THREADS-1:0]          r_fu_active;
  logic [CW-1:0]                   r_count;
  logic                            r_res_timeout;

  logic                            w_accept;
  logic                            w_clear;
  logic                            w_track_en;
  logic                            w_set_timeout;
  logic                            w_fu_idle;
  logic                            w_all_done;
  logic                            w_expired;
  logic [NUM_THREADS-1:0]          w_done_mask;
  logic [NUM_THREADS-1:0]          w_done_next;
  logic [NUM_THREADS*RESULT_W-1:0] w_results;

  thread_done_tracker #(
    .NUM_THREADS (NUM_THREADS)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_enable    (w_track_en),
    .i_mask      (r_mask),
    .i_complete  (bus.fu_thread_complete),
    .i_result    (bus.fu_final_result),
    .o_done_mask (w_done_mask),
    .o_done_next (w_done_next),
    .o_results   (w_results)
  );

  assign w_all_done = (w_done_next == r_mask);
  assign w_expired  = (r_count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Completion is tested before expiry so a last-cycle completion is not a timeout.
  always_comb begin
    w_next_state  = r_state;
    w_accept      = 1'b0;
    w_clear       = 1'b0;
    w_track_en    = 1'b0;
    w_set_timeout = 1'b0;
    w_fu_idle     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid && (bus.req_type != OP_NOP)) begin
          w_accept     = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_clear = 1'b1;
        if (r_fu_type == OP_LOAD) begin
          w_next_state = ST_IDLE;
          w_fu_idle    = 1'b1;
        end else if (r_mask == '0) begin
          w_next_state = ST_RESP;
          w_fu_idle    = 1'b1;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_track_en = 1'b1;
        if (w_all_done) begin
          w_next_state = ST_RESP;
          w_fu_idle    = 1'b1;
        end else if (w_expired) begin
          w_next_state  = ST_RESP;
          w_set_timeout = 1'b1;
          w_fu_idle     = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.res_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask        <= '0;
      r_fu_type     <= OP_NOP;
      r_fu_reg1     <= '0;
      r_fu_reg2     <= '0;
      r_fu_dest     <= '0;
      r_fu_shammt   <= '0;
      r_fu_active   <= '0;
      r_count       <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mask      <= bus.req_mask;
        r_fu_type   <= bus.req_type;
        r_fu_reg1   <= bus.req_regnum_1;
        r_fu_reg2   <= bus.req_regnum_2;
        r_fu_dest   <= bus.req_dest_reg;
        r_fu_shammt <= bus.req_shammt;
        r_fu_active <= bus.req_mask;
      end
      if (w_fu_idle) begin
        r_fu_type   <= OP_NOP;
        r_fu_active <= '0;
      end
      if (w_clear) begin
        r_count       <= '0;
        r_res_timeout <= 1'b0;
      end else if (w_track_en) begin
        r_count <= r_count + CW'(1);
      end
      if (w_set_timeout) begin
        r_res_timeout <= 1'b1;
      end
    end
  end

  assign bus.req_ready           = (r_state == ST_IDLE);
  assign bus.busy                = (r_state != ST_IDLE);
  assign bus.res_valid           = (r_state == ST_RESP);
  assign bus.res_data            = w_results;
  assign bus.res_mask            = w_done_mask;
  assign bus.res_timeout         = r_res_timeout;
  assign bus.fu_type_instruction = r_fu_type;
  assign bus.fu_regnum_1         = r_fu_reg1;
  assign bus.fu_regnum_2         = r_fu_reg2;
  assign bus.fu_dest_reg         = r_fu_dest;
  assign bus.fu_shammt           = r_fu_shammt;
  assign bus.fu_is_active        = r_fu_active;

endmodule

// File: tb/tb_thread_dispatcher.sv
// Self-checking bench for thread_dispatcher: per-scenario tasks compare the DUT
// against a completion-time model of the dispatcher's response.
module tb_thread_dispatcher;
  import gpu_pkg::*;

  localparam int NT    = 4;
  localparam int TO    = 8;
  localparam int NEVER = 1000;
  localparam logic [35:0] RESET_OUTS = {1'b1, 1'b0, 3'b111, 4'b0, 21'b0, 1'b0, 4'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // Per-lane first WAIT cycle (0-based) of completion, and value presented per WAIT cycle.
  int          laneComp [NT];
  logic [31:0] laneVal  [NT][32];

  typedef struct {
    int              respT;
    int              readyT;
    int              typeCycles;
    logic [2:0]      iType;
    logic [NT-1:0]   iActive;
    logic [20:0]     iFields;
    logic [2:0]      rType;
    logic [NT-1:0]   rActive;
    logic [NT*32-1:0] data;
    logic [NT-1:0]   rmask;
    logic            rto;
  } obs_t;

  typedef struct {
    int               respT;
    logic [NT-1:0]    rmask;
    logic             rto;
    logic [NT*32-1:0] data;
  } exp_t;

  thread_dispatcher_if #(.NUM_THREADS(NT)) bus ();

  thread_dispatcher #(
    .NUM_THREADS (NT),
    .TIMEOUT     (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] outVector();
    return {bus.req_ready, bus.busy, bus.fu_type_instruction, bus.fu_is_active,
            bus.fu_regnum_1, bus.fu_regnum_2, bus.fu_dest_reg, bus.fu_shammt,
            bus.res_valid, bus.res_mask, bus.res_timeout};
  endfunction

  // Response predicted from completion times: the latest active completion sets
  // the latency unless it lies beyond the timeout window.
  function automatic exp_t model(input logic [NT-1:0] mask);
    exp_t e;
    int   last;
    bit   all;
    e.rmask = '0;
    e.rto   = 1'b0;
    e.data  = '0;
    e.respT = 2;
    last    = 0;
    all     = 1'b1;
    if (mask == '0) return e;
    for (int i = 0; i < NT; i++) begin
      if (mask[i]) begin
        if (laneComp[i] <= TO - 1) begin
          e.rmask[i]        = 1'b1;
          e.data[i*32 +: 32] = laneVal[i][laneComp[i]];
          if (laneComp[i] > last) last = laneComp[i];
        end else begin
          all = 1'b0;
        end
      end
    end
    if (all) begin
      e.respT = 3 + last;
    end else begin
      e.respT = 2 + TO;
      e.rto   = 1'b1;
    end
    return e;
  endfunction

  task automatic randomizeVals();
    for (int i = 0; i < NT; i++)
      for (int k = 0; k < 32; k++)
        laneVal[i][k] = $urandom;
  endtask

  task automatic driveLanes(input int w);
    for (int i = 0; i < NT; i++) begin
      bus.fu_thread_complete[i]     = (w >= 0) && (w >= laneComp[i]);
      bus.fu_final_result[i*32 +: 32] = (w >= 0) ? laneVal[i][w] : 32'h0;
    end
  endtask

  // Issues one request from IDLE and follows it until res_valid or a 30-cycle bound.
  task automatic runTxn(input logic [2:0] typ, input logic [NT-1:0] mask,
                        input logic [20:0] fields, output obs_t o);
    o.respT = -1; o.readyT = -1; o.typeCycles = 0;
    o.iType = '0; o.iActive = '0; o.iFields = '0;
    o.rType = '0; o.rActive = '0; o.data = '0; o.rmask = '0; o.rto = 1'b0;
    bus.req_type = typ;
    bus.req_mask = mask;
    {bus.req_regnum_1, bus.req_regnum_2, bus.req_dest_reg, bus.req_shammt} = fields;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      if (t == 1) begin
        o.iType   = bus.fu_type_instruction;
        o.iActive = bus.fu_is_active;
        o.iFields = {bus.fu_regnum_1, bus.fu_regnum_2, bus.fu_dest_reg, bus.fu_shammt};
      end
      if (bus.fu_type_instruction === typ) o.typeCycles++;
      if (o.readyT < 0 && bus.req_ready === 1'b1) o.readyT = t;
      if (bus.res_valid === 1'b1) begin
        o.respT   = t;
        o.rType   = bus.fu_type_instruction;
        o.rActive = bus.fu_is_active;
        o.data    = bus.res_data;
        o.rmask   = bus.res_mask;
        o.rto     = bus.res_timeout;
        break;
      end
      driveLanes(t - 2);
      tick();
    end
  endtask

  task automatic finishResp();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    driveLanes(-1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    tick();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.fu_type_instruction !== 3'b111) begin errors++; $display("[TB] FAIL reset_fu_type: got %b expected 111", bus.fu_type_instruction); end
    checks++; if (outVector() !== RESET_OUTS) begin errors++; $display("[TB] FAIL reset_outputs: got %h expected %h", outVector(), RESET_OUTS); end
    checks++; if (bus.res_data !== '0) begin errors++; $display("[TB] FAIL reset_res_data: got %h expected 0", bus.res_data); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_add_staggered();
    obs_t o;
    exp_t e;
    randomizeVals();
    laneComp = '{1, 2, 2, 4};
    e = model(4'b1111);
    runTxn(3'b000, 4'b1111, {5'd1, 5'd9, 5'd3, 6'd0}, o);
    checks++; if (o.iType !== 3'b000) begin errors++; $display("[TB] FAIL add_issue_type: got %b expected 000", o.iType); end
    checks++; if (o.iActive !== 4'b1111) begin errors++; $display("[TB] FAIL add_issue_active: got %b expected 1111", o.iActive); end
    checks++; if (o.iFields !== {5'd1, 5'd9, 5'd3, 6'd0}) begin errors++; $display("[TB] FAIL add_issue_fields: got %h expected %h", o.iFields, {5'd1, 5'd9, 5'd3, 6'd0}); end
    checks++; if (o.respT !== e.respT) begin errors++; $display("[TB] FAIL add_resp_time: got %0d expected %0d", o.respT, e.respT); end
    checks++; if (o.rmask !== e.rmask || o.rto !== e.rto) begin errors++; $display("[TB] FAIL add_resp_mask_to: got %b/%b expected %b/%b", o.rmask, o.rto, e.rmask, e.rto); end
    checks++; if (o.data !== e.data) begin errors++; $display("[TB] FAIL add_resp_data: got %h expected %h", o.data, e.data); end
    checks++; if ({o.rType, o.rActive} !== {3'b111, 4'b0}) begin errors++; $display("[TB] FAIL add_resp_fu_idle: got %b/%b expected 111/0000", o.rType, o.rActive); end
    finishResp();
    checks++; if ({bus.req_ready, bus.res_valid} !== 2'b10) begin errors++; $display("[TB] FAIL add_after_handshake: got %b expected 10", {bus.req_ready, bus.res_valid}); end
  endtask

  task automatic test_load();
    obs_t o;
    randomizeVals();
    laneComp = '{NEVER, NEVER, NEVER, NEVER};
    runTxn(3'b110, 4'b1111, 21'($urandom), o);
    checks++; if (o.iType !== 3'b110) begin errors++; $display("[TB] FAIL load_issue_type: got %b expected 110", o.iType); end
    checks++; if (o.typeCycles !== 1) begin errors++; $display("[TB] FAIL load_type_cycles: got %0d expected 1", o.typeCycles); end
    checks++; if (o.respT !== -1) begin errors++; $display("[TB] FAIL load_no_response: got %0d expected -1", o.respT); end
    checks++; if (o.readyT !== 2) begin errors++; $display("[TB] FAIL load_ready_return: got %0d expected 2", o.readyT); end
    driveLanes(-1);
  endtask

  task automatic test_mask_stray();
    obs_t o;
    exp_t e;
    randomizeVals();
    laneComp = '{1, 0, 3, 0};
    e = model(4'b0101);
    runTxn(3'b000, 4'b0101, 21'($urandom), o);
    checks++; if (o.respT !== e.respT) begin errors++; $display("[TB] FAIL stray_resp_time: got %0d expected %0d", o.respT, e.respT); end
    checks++; if (o.rmask !== 4'b0101) begin errors++; $display("[TB] FAIL stray_res_mask: got %b expected 0101", o.rmask); end
    checks++; if (o.data !== e.data || o.rto !== 1'b0) begin errors++; $display("[TB] FAIL stray_res_data: got %h/%b expected %h/0", o.data, o.rto, e.data); end
    finishResp();
  endtask

  task automatic test_timeout();
    obs_t o;
    exp_t e;
    randomizeVals();
    laneComp = '{0, 3, NEVER, 5};
    e = model(4'b1111);
    runTxn(3'b000, 4'b1111, 21'($urandom), o);
    checks++; if (o.respT !== 2 + TO) begin errors++; $display("[TB] FAIL timeout_resp_time: got %0d expected %0d", o.respT, 2 + TO); end
    checks++; if (o.rto !== 1'b1 || o.rmask !== 4'b1011) begin errors++; $display("[TB] FAIL timeout_flag_mask: got %b/%b expected 1/1011", o.rto, o.rmask); end
    checks++; if (o.data !== e.data || o.data[95:64] !== 32'h0) begin errors++; $display("[TB] FAIL timeout_res_data: got %h expected %h", o.data, e.data); end
    finishResp();

    randomizeVals();
    laneComp = '{2, TO - 1, NEVER, NEVER};
    e = model(4'b0011);
    runTxn(3'b000, 4'b0011, 21'($urandom), o);
    checks++; if (o.respT !== e.respT || o.rto !== 1'b0) begin errors++; $display("[TB] FAIL timeout_boundary: got t=%0d to=%b expected t=%0d to=0", o.respT, o.rto, e.respT); end
    checks++; if (o.rmask !== 4'b0011 || o.data !== e.data) begin errors++; $display("[TB] FAIL timeout_boundary_data: got %b %h expected 0011 %h", o.rmask, o.data, e.data); end
    finishResp();
  endtask

  task automatic test_zero_mask_and_nop();
    obs_t o;
    randomizeVals();
    laneComp = '{0, 0, 0, 0};
    runTxn(3'b000, 4'b0000, 21'($urandom), o);
    checks++; if (o.respT !== 2) begin errors++; $display("[TB] FAIL zero_resp_time: got %0d expected 2", o.respT); end
    checks++; if ({o.rmask, o.rto, o.iActive} !== 9'b0 || o.data !== '0) begin errors++; $display("[TB] FAIL zero_resp_fields: got %b/%b/%b %h expected zeros", o.rmask, o.rto, o.iActive, o.data); end
    finishResp();

    bus.req_type  = 3'b111;
    bus.req_mask  = 4'b1111;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    checks++; if ({bus.req_ready, bus.busy, bus.fu_type_instruction} !== 5'b10111) begin errors++; $display("[TB] FAIL nop_dropped: got %b expected 10111", {bus.req_ready, bus.busy, bus.fu_type_instruction}); end
  endtask

  task automatic test_backpressure();
    obs_t o;
    exp_t e;
    logic [NT*32-1:0] drainData;
    bit found;
    randomizeVals();
    for (int i = 0; i < NT; i++) laneComp[i] = $urandom_range(0, 3);
    e = model(4'b1111);
    runTxn(3'b000, 4'b1111, 21'($urandom), o);
    checks++; if (o.respT !== e.respT) begin errors++; $display("[TB] FAIL bp_resp_time: got %0d expected %0d", o.respT, e.respT); end
    bus.req_type  = 3'b000;
    bus.req_mask  = 4'b1111;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if ({bus.res_valid, bus.req_ready} !== 2'b10) begin errors++; $display("[TB] FAIL bp_hold_state: got %b expected 10", {bus.res_valid, bus.req_ready}); end
      checks++; if (bus.res_data !== e.data || bus.res_mask !== e.rmask || bus.res_timeout !== e.rto) begin errors++; $display("[TB] FAIL bp_hold_fields: got %h %b %b expected %h %b %b", bus.res_data, bus.res_mask, bus.res_timeout, e.data, e.rmask, e.rto); end
    end
    drainData = {$urandom, $urandom, $urandom, $urandom};
    bus.fu_thread_complete = '1;
    bus.fu_final_result    = drainData;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checks++; if ({bus.req_ready, bus.res_valid} !== 2'b10) begin errors++; $display("[TB] FAIL bp_ready_return: got %b expected 10", {bus.req_ready, bus.res_valid}); end
    tick();
    bus.req_valid = 1'b0;
    checks++; if ({bus.busy, bus.fu_type_instruction} !== 4'b1000) begin errors++; $display("[TB] FAIL bp_next_accept: got %b expected 1000", {bus.busy, bus.fu_type_instruction}); end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (bus.res_valid === 1'b1) found = 1'b1;
      else tick();
    end
    checks++; if (!found || bus.res_data !== drainData) begin errors++; $display("[TB] FAIL bp_drain_resp: got valid=%b %h expected valid=1 %h", found, bus.res_data, drainData); end
    finishResp();
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    logic [NT-1:0] mask;
    randomizeVals();
    laneComp = '{0, NEVER, NEVER, NEVER};
    bus.req_type  = 3'b000;
    bus.req_mask  = 4'b1111;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    driveLanes(-1);
    tick();
    driveLanes(0);
    tick();
    driveLanes(1);
    checks++; if ({bus.busy, bus.res_valid} !== 2'b10) begin errors++; $display("[TB] FAIL midrst_waiting: got %b expected 10", {bus.busy, bus.res_valid}); end
    rst = 1'b0;
    #1;
    checks++; if (outVector() !== RESET_OUTS) begin errors++; $display("[TB] FAIL midrst_outputs: got %h expected %h", outVector(), RESET_OUTS); end
    checks++; if (bus.res_data !== '0) begin errors++; $display("[TB] FAIL midrst_res_data: got %h expected 0", bus.res_data); end
    driveLanes(-1);
    tick();
    rst = 1'b1;
    randomizeVals();
    for (int i = 0; i < NT; i++) laneComp[i] = $urandom_range(0, 4);
    mask = NT'($urandom_range(1, 15));
    e = model(mask);
    runTxn(3'b000, mask, 21'($urandom), o);
    checks++; if (o.respT !== e.respT || o.rmask !== e.rmask || o.rto !== e.rto) begin errors++; $display("[TB] FAIL midrst_fresh_resp: got t=%0d %b %b expected t=%0d %b %b", o.respT, o.rmask, o.rto, e.respT, e.rmask, e.rto); end
    checks++; if (o.data !== e.data) begin errors++; $display("[TB] FAIL midrst_fresh_data: got %h expected %h", o.data, e.data); end
    finishResp();
  endtask

  task automatic test_random_back_to_back();
    obs_t o;
    exp_t e;
    logic [NT-1:0] mask;
    logic [2:0]    typ;
    logic [20:0]   fields;
    for (int n = 0; n < 25; n++) begin
      randomizeVals();
      for (int i = 0; i < NT; i++) laneComp[i] = $urandom_range(0, TO + 1);
      mask   = NT'($urandom_range(0, 15));
      typ    = 3'($urandom_range(0, 5));
      fields = 21'($urandom);
      e = model(mask);
      runTxn(typ, mask, fields, o);
      checks++; if ({o.iType, o.iActive, o.iFields} !== {typ, mask, fields}) begin errors++; $display("[TB] FAIL rnd%0d_issue: got %h expected %h", n, {o.iType, o.iActive, o.iFields}, {typ, mask, fields}); end
      checks++; if (o.respT !== e.respT) begin errors++; $display("[TB] FAIL rnd%0d_resp_time: got %0d expected %0d", n, o.respT, e.respT); end
      checks++; if (o.rmask !== e.rmask || o.rto !== e.rto) begin errors++; $display("[TB] FAIL rnd%0d_mask_to: got %b/%b expected %b/%b", n, o.rmask, o.rto, e.rmask, e.rto); end
      checks++; if (o.data !== e.data) begin errors++; $display("[TB] FAIL rnd%0d_data: got %h expected %h", n, o.data, e.data); end
      checks++; if ({o.rType, o.rActive} !== {3'b111, 4'b0}) begin errors++; $display("[TB] FAIL rnd%0d_fu_idle: got %b/%b expected 111/0000", n, o.rType, o.rActive); end
      finishResp();
    end
  endtask

  initial begin
    bus.req_valid          = 1'b0;
    bus.req_type           = 3'b111;
    bus.req_regnum_1       = '0;
    bus.req_regnum_2       = '0;
    bus.req_dest_reg       = '0;
    bus.req_shammt         = '0;
    bus.req_mask           = '0;
    bus.fu_thread_complete = '0;
    bus.fu_final_result    = '0;
    bus.res_ready          = 1'b0;
    laneComp = '{NEVER, NEVER, NEVER, NEVER};

    test_reset();
    test_add_staggered();
    test_load();
    test_mask_stray();
    test_timeout();
    test_zero_mask_and_nop();
    test_backpressure();
    test_reset_mid();
    test_random_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/thread_dispatcher.md
# thread_dispatcher

Sequencing controller for a group of `func_unit` lanes. It accepts one instruction at a time over a valid/ready request port and broadcasts the decoded fields to all lanes, gated per lane by an active mask. It then waits until every active lane raises `thread_complete`, or until a timeout expires, and returns the captured per-lane results over a valid/ready response port.

## Interface
- `NUM_THREADS`, default 4: number of `func_unit` lanes driven.
- `TIMEOUT`, default 64: maximum number of cycles spent waiting for completion before the block gives up.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: dispatcher can accept a request.
- `req_type` input 3: instruction type (`000` add, `110` load regfile, `111` nop).
- `req_regnum_1`, `req_regnum_2`, `req_dest_reg` input 5 each: register indices.
- `req_shammt` input 6: shift amount.
- `req_mask` input NUM_THREADS: lanes that execute this instruction.
- `fu_type_instruction` output 3: broadcast to all lanes.
- `fu_regnum_1`, `fu_regnum_2`, `fu_dest_reg` output 5 each; `fu_shammt` output 6: broadcast fields.
- `fu_is_active` output NUM_THREADS: per-lane `is_active`.
- `fu_thread_complete` input NUM_THREADS: per-lane completion.
- `fu_final_result` input NUM_THREADS×32: per-lane result.
- `res_valid` output 1: response present.
- `res_ready` input 1: consumer accepts the response.
- `res_data` output NUM_THREADS×32: captured results.
- `res_mask` output NUM_THREADS: lanes that completed.
- `res_timeout` output 1: response was produced by the timeout path.
- `busy` output 1: state is not IDLE.

## Operation
- States are IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - `req_ready`=1.
  - When `req_valid` and `req_ready` are both high, all request fields are latched and the next state is ISSUE.
  - A `111` request is accepted and dropped; the state stays IDLE.
- **ISSUE** (exactly 1 cycle)
  - `fu_*` outputs carry the latched fields; `fu_is_active` = latched mask.
  - `done_mask` and the timeout counter are cleared.
  - A `110` (load) request goes next to IDLE and produces no response.
  - A mask of all zeros goes next to RESP with `res_mask`=0.
  - Every other request goes next to WAIT.
- **WAIT**
  - `fu_*` outputs stay held.
  - Each cycle: `done_mask |= fu_thread_complete & mask`.
  - A lane's `fu_final_result` is captured on the first cycle its completion is seen; later changes on that lane are ignored.
  - Completion on a lane outside the mask is ignored.
  - When `done_mask | new completions` equals the mask, the next state is RESP with `res_timeout`=0.
  - The counter increments each WAIT cycle. If it reaches TIMEOUT-1 without full completion, the next state is RESP with `res_timeout`=1.
  - If completion and timeout occur in the same cycle, completion wins and `res_timeout`=0.
- **RESP**
  - `fu_type_instruction`=`111`, `fu_is_active`=0.
  - `res_valid`=1, `res_data`, `res_mask` (= `done_mask`) and `res_timeout` are all stable.
  - When `res_ready` is high, the next state is IDLE. No new request is accepted until then.
- Lanes that did not complete read 0 in `res_data`.

## Timing
- All outputs are registered, or decoded directly from the state register.
- Reset values:
  - state IDLE, `req_ready`=1, `busy`=0;
  - `fu_type_instruction`=`111`, other `fu_*` fields 0, `fu_is_active`=0;
  - `res_valid`=0, `res_data`=0, `res_mask`=0, `res_timeout`=0.
- Latency: request accepted at edge N → ISSUE during cycle N+1 → WAIT from cycle N+2.
- Full completion sampled in cycle K → `res_valid` high in cycle K+1.
- Minimum request-to-response time (all lanes complete in their first WAIT cycle) is 3 cycles.
- Back-to-back: `req_ready` returns in the cycle after the `res_valid`/`res_ready` handshake.
- Reset asserted mid-operation immediately forces every output to its reset value and discards captured results.

## Structure
- Shared package `gpu_pkg` holds:
  - `instr_type_e` with `OP_ADD`=3'b000, `OP_LOAD`=3'b110, `OP_NOP`=3'b111;
  - `dispatch_state_e`;
  - `NUM_THREADS_DEFAULT`.
- One sub-module, `thread_done_tracker`: holds the sticky `done_mask` and the per-lane result capture registers, with clear/enable inputs from the FSM.

## Test plan
- Mask `1111`, add r1+r9→r3; lanes complete in cycles 2, 3, 3, 5 of WAIT → `res_valid` one cycle after the last completion, `res_mask`=`1111`, `res_timeout`=0, each lane's result equals the value it presented in its completion cycle.
- Load (`110`) request → `fu_type_instruction`=`110` for exactly one cycle, `res_valid` never rises, `req_ready`=1 two cycles after acceptance.
- Mask `0101`, lanes 1 and 3 also raise complete → their completions are ignored and `res_mask`=`0101`.
- TIMEOUT=8, lane 2 never completes → `res_timeout`=1, `res_mask`=`1011`, `res_data[2]`=0, response 8 WAIT cycles after entry.
- `res_ready` held low for 4 cycles → response fields stable, a new `req_valid` is not accepted; after the handshake, the next request is accepted one cycle later.
- `rst` pulsed low during WAIT → all outputs return to their reset values immediately; after release, a fresh request completes normally.
